// File: rtl/serial_logic_reduce.sv
// Bit-serial AND/OR/XOR/XNOR reduction of a WIDTH-bit word, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module serial_logic_reduce #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic [1:0]       up_mode,
    output logic             down_valid,
    input  logic             down_ready,
    output logic             down_data
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_XNOR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("serial_logic_reduce: WIDTH must be in 2..64");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [1:0]       mode_reg;
    logic             acc;
    logic [CNT_W-1:0] cnt;

    logic             cur_bit;
    logic             mux_one;
    logic             mux_zero;
    logic             acc_step;

    // The mode only picks what feeds the two mux legs; the current bit is the select.
    always_comb begin
        cur_bit  = shift_reg[0];
        mux_one  = acc;
        mux_zero = acc;
        case (mode_reg)
            MODE_AND: begin
                mux_one  = acc;
                mux_zero = 1'b0;
            end
            MODE_OR: begin
                mux_one  = 1'b1;
                mux_zero = acc;
            end
            MODE_XOR, MODE_XNOR: begin
                mux_one  = ~acc;
                mux_zero = acc;
            end
            default: begin
                mux_one  = acc;
                mux_zero = acc;
            end
        endcase
        acc_step = cur_bit ? mux_one : mux_zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            mode_reg  <= MODE_AND;
            acc       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (up_valid) begin
                        shift_reg <= up_data;
                        mode_reg  <= up_mode;
                        acc       <= (up_mode == MODE_AND);
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    acc       <= acc_step;
                    shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
                    cnt       <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (down_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign up_ready   = (state == IDLE);
    assign down_valid = (state == DONE);
    // XNOR shares the XOR accumulator and inverts only at the output.
    assign down_data  = (state == DONE) & (acc ^ (mode_reg == MODE_XNOR));

endmodule

// File: doc/serial_logic_reduce.md
Name: serial_logic_reduce

Overview:
- Bit-serial logic-reduction unit. Reduces a WIDTH-bit word to one bit (AND / OR / XOR / XNOR), processing one bit per clock through a single 2:1 mux datapath.
- Parametrised, sequential successor to the single-mux gate blocks in the combinational section.
- Sits between an upstream producer and a downstream consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- up_valid  input  1  upstream word available.
- up_ready  output  1  block can accept a word this cycle.
- up_data  input  WIDTH  operand word.
- up_mode  input  2  reduction mode: 00 AND, 01 OR, 10 XOR, 11 XNOR.
- down_valid  output  1  result available.
- down_ready  input  1  downstream accepts result.
- down_data  output  1  reduction result.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - up_ready = 1 from the first cycle after reset.
  - down_valid = 0 and down_data = 0.
  - Shift register, accumulator and bit counter = 0.
- States: IDLE, BUSY, DONE. Encoding is free.
- up_ready = (state == IDLE), purely from state. down_valid = (state == DONE).

IDLE:
- On up_valid & up_ready, capture up_data into the shift register and up_mode into the mode register.
- Initialise the accumulator: 1 for AND, 0 for OR/XOR/XNOR.
- Set counter = 0 and move to BUSY.
- Data and mode presented without up_valid are ignored.

BUSY:
- Each cycle, take bit b = shift_reg[0] (LSB first) and update the accumulator through one 2:1 mux selected by b:
  - AND: acc <= b ? acc : 0
  - OR: acc <= b ? 1 : acc
  - XOR/XNOR: acc <= b ? ~acc : acc
- Shift the register right by 1 and increment the counter.
- When counter == WIDTH-1, the final bit is processed that cycle and the state moves to DONE.
- No early termination: latency is fixed.
- Counter width is $clog2(WIDTH).

DONE:
- down_data = acc for AND/OR/XOR; ~acc for XNOR.
- down_valid and down_data stay stable until down_ready is sampled high.
- On down_valid & down_ready, go to IDLE.
- up_ready = 0 throughout BUSY and DONE: no overlap and no input buffering.

Timing:
- Acceptance edge at cycle T gives down_valid high at cycle T+WIDTH+1 (WIDTH BUSY cycles).
- Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH BUSY, one DONE cycle with down_ready already high).

Boundary conditions:
- down_ready held high ahead of DONE: the result is consumed in its first DONE cycle and the block is back in IDLE the next cycle.
- down_ready low: the result is held indefinitely. Upstream stays stalled (up_ready = 0).
- up_valid held high continuously: a new word is accepted on the first IDLE cycle after each completion.
- Reset mid-BUSY or in DONE:
  - The operation is discarded and no result is emitted.
  - down_valid = 0 on the cycle after the rst edge.
  - up_ready = 1 once rst deasserts.
- rst has priority over every handshake in the same cycle.
- up_mode changes after acceptance have no effect on the operation in flight.

Test Plan:
- Reset, then each mode on 8'hFF with down_ready held high -> AND=1, OR=1, XOR=0, XNOR=1; down_valid rises exactly 9 cycles after the accept edge.
- up_data=8'hFE, mode AND -> 0. Same word, mode OR -> 1. up_data=8'h00, mode OR -> 0.
- up_data=8'b1011_0001 (popcount 4) -> XOR=0, XNOR=1. up_data=8'b1011_0011 -> XOR=1, XNOR=0.
- Backpressure: hold down_ready=0 for 5 cycles after down_valid -> down_valid/down_data stable, up_ready=0; raise down_ready -> IDLE next cycle, next word accepted.
- Reset at the 4th BUSY cycle of an XOR on 8'h01 -> no down_valid pulse. A following AND on 8'hFF returns 1 with the normal 9-cycle latency.
- WIDTH=2 and WIDTH=64 builds: random words vs reference reductions across all four modes with back-to-back up_valid -> all match; initiation interval = WIDTH+2 when down_ready is always high.
